// File: rtl/cfg_chain_driver.sv
// rtl/cfg_chain_driver.sv - serial config-frame source for the tile daisy chain
// Build option CFG_PARITY_EN adds parity_o, the running XOR of the payload bits sent.
module cfg_chain_driver #(
    parameter int NUM_TILES  = 9,
    parameter int MEM_CYCLES = 32768,
    parameter int WORD_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [NUM_TILES-1:0] tile_mask_i,
    input  logic [WORD_W-1:0]    wr_data_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    output logic                 chain_out_o,
    output logic                 chain_rst_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 underrun_o
`ifdef CFG_PARITY_EN
    ,
    output logic                 parity_o
`endif
);
    localparam int WORDS_PER_TILE = MEM_CYCLES / WORD_W;
    localparam int TOTAL_WORDS    = NUM_TILES * WORDS_PER_TILE;
    localparam int HW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int CW = $clog2(TOTAL_WORDS + 1);
    localparam logic [HW-1:0] HDR_LAST   = HW'(NUM_TILES - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_W - 1);
    localparam logic [CW-1:0] WORD_LAST  = CW'(TOTAL_WORDS - 1);
    localparam logic [CW-1:0] WORD_TOTAL = CW'(TOTAL_WORDS);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;

    state_t               state_q;
    logic [NUM_TILES-1:0] tile_mask_q;
    logic [HW-1:0]        hdr_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [CW-1:0]        word_cnt_q;
    logic [CW-1:0]        accepted_q, accepted_d;
    logic [WORD_W-1:0]    cur_word_q;
    logic                 chain_out_q, chain_rst_q, busy_q, done_q, underrun_q;
    logic                 wr_ready_q, wr_ready_d;

    logic [WORD_W-1:0]    fifo_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q, count_d;
    logic                 push, pop_slot, pop, payload_bit;
    logic [WORD_W-1:0]    pop_word;

    // An empty FIFO at a word boundary sends a zero word instead of stalling the frame.
    assign push        = wr_valid_i && wr_ready_q;
    assign pop_slot    = (state_q == PAYLOAD) && (bit_cnt_q == '0);
    assign pop         = pop_slot && (count_q != 2'd0);
    assign pop_word    = pop ? fifo_q[rd_ptr_q] : '0;
    assign payload_bit = pop_slot ? pop_word[0] : cur_word_q[bit_cnt_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        accepted_d = accepted_q + CW'(push);
        if (state_q == DONE) begin
            accepted_d = CW'(push);
        end
        wr_ready_d = (count_d != 2'd2) && (accepted_d < WORD_TOTAL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            tile_mask_q <= '0;
            hdr_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            accepted_q  <= '0;
            cur_word_q  <= '0;
            chain_out_q <= 1'b0;
            chain_rst_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            wr_ready_q  <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            count_q    <= count_d;
            accepted_q <= accepted_d;
            wr_ready_q <= wr_ready_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q         <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            case (state_q)
                IDLE: begin
                    chain_out_q <= 1'b0;
                    chain_rst_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    if (start_i) begin
                        tile_mask_q <= tile_mask_i;
                        underrun_q  <= 1'b0;
                        hdr_cnt_q   <= '0;
                        state_q     <= HEADER;
                    end
                end
                HEADER: begin
                    chain_out_q <= tile_mask_q[hdr_cnt_q];
                    chain_rst_q <= 1'b1;
                    busy_q      <= 1'b1;
                    if (hdr_cnt_q == HDR_LAST) begin
                        bit_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        state_q    <= PAYLOAD;
                    end else begin
                        hdr_cnt_q <= hdr_cnt_q + HW'(1);
                    end
                end
                PAYLOAD: begin
                    chain_out_q <= payload_bit;
                    if (pop_slot) begin
                        cur_word_q <= pop_word;
                        if (!pop) begin
                            underrun_q <= 1'b1;
                        end
                    end
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_q <= '0;
                        if (word_cnt_q == WORD_LAST) begin
                            state_q <= DONE;
                        end else begin
                            word_cnt_q <= word_cnt_q + CW'(1);
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                end
                DONE: begin
                    chain_out_q <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CFG_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if ((state_q == IDLE) && start_i) begin
            parity_q <= 1'b0;
        end else if (state_q == PAYLOAD) begin
            parity_q <= parity_q ^ payload_bit;
        end
    end

    assign parity_o = parity_q;
`endif

    assign wr_ready_o  = wr_ready_q;
    assign chain_out_o = chain_out_q;
    assign chain_rst_o = chain_rst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign underrun_o  = underrun_q;
endmodule

// File: tb/tb_cfg_chain_driver.sv
// tb/tb_cfg_chain_driver.sv - directed bench for cfg_chain_driver (3 tiles, 8 cycles, 4-bit words)
module tb_cfg_chain_driver;
    localparam int NT = 3;
    localparam int MC = 8;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic [NT-1:0] tile_mask_i = '0;
    logic [WW-1:0] wr_data_i = '0;
    logic          wr_valid_i = 1'b0;
    logic          wr_ready_o, chain_out_o, chain_rst_o, busy_o, done_o, underrun_o;
`ifdef CFG_PARITY_EN
    logic          parity_o;
    logic          par28;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cfg_chain_driver #(.NUM_TILES(NT), .MEM_CYCLES(MC), .WORD_W(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .tile_mask_i(tile_mask_i),
        .wr_data_i  (wr_data_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .chain_out_o(chain_out_o),
        .chain_rst_o(chain_rst_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .underrun_o (underrun_o)
`ifdef CFG_PARITY_EN
        ,
        .parity_o   (parity_o)
`endif
    );

    logic [WW-1:0] wq[$];
    logic          co[0:32];
    logic          bz[0:32];
    logic          cr[0:32];
    int            acc, acc27, dcount, dpos;
    logic          rdy27, rdy28, und28;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int which, input int lo, input int hi);
        logic [31:0] v;
        v = '0;
        for (int c = lo; c <= hi; c++) begin
            v = {v[30:0], (which == 0) ? co[c] : ((which == 1) ? bz[c] : cr[c])};
        end
        return v;
    endfunction

    // Records one frame; cycle c is sampled just after edge N+c, where edge N accepts start.
    task automatic run_frame(input logic [NT-1:0] mask, input int npre, input int hold_after,
                             input int hold_until, input bit hold_start);
        logic r;
        acc    = 0;
        dcount = 0;
        dpos   = -1;
        for (int i = 0; i < npre; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = wq[0];
            r = wr_ready_o;
            step();
            if (r) begin
                wq.delete(0);
                acc++;
            end
        end
        wr_valid_i  = 1'b0;
        start_i     = 1'b1;
        tile_mask_i = mask;
        step();
        co[0] = chain_out_o;
        bz[0] = busy_o;
        cr[0] = chain_rst_o;
        for (int c = 1; c <= 32; c++) begin
            start_i    = hold_start && (c <= 28);
            wr_valid_i = (wq.size() > 0) && !((acc >= hold_after) && (c <= hold_until));
            if (wq.size() > 0) wr_data_i = wq[0];
            r = wr_ready_o;
            step();
            if (wr_valid_i && r) begin
                wq.delete(0);
                acc++;
            end
            co[c] = chain_out_o;
            bz[c] = busy_o;
            cr[c] = chain_rst_o;
            if (done_o) begin
                dcount++;
                dpos = c;
            end
            if (c == 27) begin
                acc27 = acc;
                rdy27 = wr_ready_o;
            end
            if (c == 28) begin
                rdy28 = wr_ready_o;
                und28 = underrun_o;
`ifdef CFG_PARITY_EN
                par28 = parity_o;
`endif
            end
        end
        wr_valid_i = 1'b0;
        start_i    = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        step(); step(); step();
        check1("rst_chain_out", chain_out_o, 1'b0);
        check1("rst_chain_rst", chain_rst_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_done", done_o, 1'b0);
        check1("rst_underrun", underrun_o, 1'b0);
        check1("rst_wr_ready", wr_ready_o, 1'b0);
        rst = 1'b1;
        step();
        check1("idle_wr_ready", wr_ready_o, 1'b1);

        // Frame 1: prefill two words, four more back-to-back
        wq = '{4'hA, 4'h5, 4'hF, 4'h0, 4'h3, 4'hC};
        run_frame(3'b101, 2, 99, 0, 1'b0);
        check32("f1_stream", pack(0, 1, 27), 32'(27'b101_0101_1010_1111_0000_1100_0011));
        check32("f1_done_pos", dpos, 28);
        check32("f1_done_cnt", dcount, 1);
        check32("f1_busy", pack(1, 0, 29), 32'h1FFF_FFFE);
        check32("f1_chain_rst", pack(2, 0, 29), 32'h1FFF_FFFE);
        check1("f1_underrun", und28, 1'b0);
        check32("f1_accepted", acc, 6);
`ifdef CFG_PARITY_EN
        check1("f1_parity", par28, 1'b0);
`endif

        // Frame 2: start held high, seven words pushed continuously
        wq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        run_frame(3'b110, 0, 99, 0, 1'b1);
        check32("f2_stream", pack(0, 1, 27), 32'(27'b011_1000_0100_1100_0010_1010_0110));
        check32("f2_done_pos", dpos, 28);
        check32("f2_done_cnt", dcount, 1);
        check32("f2_busy", pack(1, 0, 29), 32'h1FFF_FFFE);
        check32("f2_acc_before_done", acc27, 6);
        check1("f2_ready_before_done", rdy27, 1'b0);
        check1("f2_ready_after_done", rdy28, 1'b1);
        check32("f2_acc_total", acc, 7);
`ifdef CFG_PARITY_EN
        check1("f2_parity", par28, 1'b1);
`endif

        // Frame 3: leftover word 7 first, word for slot 3 withheld past its slot
        wq = '{4'h9, 4'h1, 4'hE, 4'h6};
        run_frame(3'b011, 0, 2, 16, 1'b0);
        check32("f3_stream", pack(0, 1, 27), 32'(27'b110_1110_1001_1000_0000_0111_0110));
        check32("f3_done_pos", dpos, 28);
        check32("f3_done_cnt", dcount, 1);
        check1("f3_underrun", und28, 1'b1);
        check1("f3_underrun_sticky", underrun_o, 1'b1);
`ifdef CFG_PARITY_EN
        check1("f3_parity", par28, 1'b1);
        check1("f3_parity_held", parity_o, 1'b1);
`endif

        // Frame 4: reset asserted in payload cycle 10
        start_i     = 1'b1;
        tile_mask_i = 3'b111;
        step();
        start_i = 1'b0;
        check1("f4_underrun_cleared", underrun_o, 1'b0);
        for (int c = 1; c <= 12; c++) step();
        check1("f4_busy_pre", busy_o, 1'b1);
        check1("f4_underrun_pre", underrun_o, 1'b1);
        rst = 1'b0;
        step();
        check1("f4_rst_chain_rst", chain_rst_o, 1'b0);
        check1("f4_rst_busy", busy_o, 1'b0);
        check1("f4_rst_chain_out", chain_out_o, 1'b0);
        check1("f4_rst_wr_ready", wr_ready_o, 1'b0);
        check1("f4_rst_done", done_o, 1'b0);
        check1("f4_rst_underrun", underrun_o, 1'b0);
        rst = 1'b1;
        dcount = 0;
        for (int c = 0; c < 35; c++) begin
            step();
            if (done_o) dcount++;
        end
        check32("f4_no_done", dcount, 0);
        check1("f4_idle_busy", busy_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
